// File: rtl/fifo_pkt_writer.sv
// ---------------------------------------------------------------------------
// fifo_pkt_writer
//   Frames an upstream payload stream into FIFO packets. Each packet is a
//   header word holding the payload length, followed by the payload words.
//   When FIFO_PKT_WRITER_CSUM_EN is defined, a trailer word is appended. It
//   holds the XOR of the header and every payload word.
//
// Parameters
//   WIDTH  data word width and width of the header length field
//   CNT_W  width of the completed-packet counter (wraps modulo 2^CNT_W)
//
// Ports
//   I_w_clk    write-domain clock (rising edge)
//   I_rst_n    asynchronous active-low reset
//   I_start    packet request, sampled only in IDLE
//   I_len      payload word count of the requested packet (0 is legal)
//   I_s_valid  upstream payload word valid
//   I_s_data   upstream payload word
//   O_s_ready  payload word accepted this cycle when high with I_s_valid
//   I_w_full   registered FIFO full flag
//   O_w_en     FIFO write enable (never high while I_w_full=1)
//   O_w_data   FIFO write data (0 whenever O_w_en=0)
//   O_busy     high whenever the FSM is not in IDLE
//   O_done     one-cycle pulse in the cycle after the last word is written
//   O_pkt_cnt  count of completed packets
//
// Optional feature macro: FIFO_PKT_WRITER_CSUM_EN (trailer checksum word)
// ---------------------------------------------------------------------------
module fifo_pkt_writer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             I_w_clk,
  input  logic             I_rst_n,
  input  logic             I_start,
  input  logic [WIDTH-1:0] I_len,
  input  logic             I_s_valid,
  input  logic [WIDTH-1:0] I_s_data,
  output logic             O_s_ready,
  input  logic             I_w_full,
  output logic             O_w_en,
  output logic [WIDTH-1:0] O_w_data,
  output logic             O_busy,
  output logic             O_done,
  output logic [CNT_W-1:0] O_pkt_cnt
);

`ifdef FIFO_PKT_WRITER_CSUM_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_TRL  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2
  } state_t;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] len_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             done_reg;
  logic [CNT_W-1:0] cnt_reg;
`ifdef FIFO_PKT_WRITER_CSUM_EN
  logic [WIDTH-1:0] csum_reg;
`endif

  logic             w_en_next;
  logic [WIDTH-1:0] w_data_next;
  logic             s_ready_next;
  logic             last_write;

  // Write-side outputs are combinational from the state register so a stalled
  // word goes out in the very cycle I_w_full drops. Reset forces the state to
  // IDLE asynchronously, which drops all of them immediately.
  always_comb begin
    w_en_next    = 1'b0;
    w_data_next  = '0;
    s_ready_next = 1'b0;
    last_write   = 1'b0;
    case (state_reg)
      S_HDR: begin
        w_en_next   = ~I_w_full;
        w_data_next = I_w_full ? '0 : len_reg;
`ifndef FIFO_PKT_WRITER_CSUM_EN
        // An empty packet ends on its header when there is no trailer.
        last_write  = ~I_w_full && (len_reg == '0);
`endif
      end
      S_PAY: begin
        s_ready_next = ~I_w_full;
        w_en_next    = I_s_valid & ~I_w_full;
        w_data_next  = (I_s_valid & ~I_w_full) ? I_s_data : '0;
        last_write   = I_s_valid & ~I_w_full & (rem_reg == WIDTH'(1));
      end
`ifdef FIFO_PKT_WRITER_CSUM_EN
      S_TRL: begin
        w_en_next   = ~I_w_full;
        w_data_next = I_w_full ? '0 : csum_reg;
        last_write  = ~I_w_full;
      end
`endif
      default: begin
        w_en_next    = 1'b0;
        w_data_next  = '0;
        s_ready_next = 1'b0;
        last_write   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_w_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
`ifdef FIFO_PKT_WRITER_CSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      done_reg <= last_write;
      if (last_write) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      case (state_reg)
        S_IDLE: begin
          if (I_start) begin
            len_reg   <= I_len;
            rem_reg   <= I_len;
`ifdef FIFO_PKT_WRITER_CSUM_EN
            csum_reg  <= '0;
`endif
            state_reg <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_en_next) begin
`ifdef FIFO_PKT_WRITER_CSUM_EN
            csum_reg <= csum_reg ^ len_reg;
            state_reg <= (len_reg != '0) ? S_PAY : S_TRL;
`else
            state_reg <= (len_reg != '0) ? S_PAY : S_IDLE;
`endif
          end
        end
        S_PAY: begin
          if (w_en_next) begin
            rem_reg <= rem_reg - WIDTH'(1);
`ifdef FIFO_PKT_WRITER_CSUM_EN
            csum_reg <= csum_reg ^ I_s_data;
            if (rem_reg == WIDTH'(1)) state_reg <= S_TRL;
`else
            if (rem_reg == WIDTH'(1)) state_reg <= S_IDLE;
`endif
          end
        end
`ifdef FIFO_PKT_WRITER_CSUM_EN
        S_TRL: begin
          if (w_en_next) state_reg <= S_IDLE;
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign O_w_en    = w_en_next;
  assign O_w_data  = w_data_next;
  assign O_s_ready = s_ready_next;
  assign O_busy    = (state_reg != S_IDLE);
  assign O_done    = done_reg;
  assign O_pkt_cnt = cnt_reg;

endmodule

// File: doc/fifo_pkt_writer.md
FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width and header length field width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the completed-packet counter width.
REQ-003 Port I_rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port I_w_clk, input, 1, write-domain clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port I_start, input, 1, packet request, sampled only in IDLE.
REQ-006 Port I_len, input, WIDTH, payload word count for the requested packet; 0 is legal.
REQ-007 Port I_s_valid, input, 1, upstream payload word valid.
REQ-008 Port I_s_data, input, WIDTH, upstream payload word.
REQ-009 Port O_s_ready, output, 1, upstream payload word accepted this cycle when high with I_s_valid.
REQ-010 Port I_w_full, input, 1, registered full flag from the FIFO write side.
REQ-011 Port O_w_en, output, 1, FIFO write enable.
REQ-012 Port O_w_data, output, WIDTH, FIFO write data.
REQ-013 Port O_busy, output, 1, high whenever state is not IDLE.
REQ-014 Port O_done, output, 1, one-cycle completion pulse.
REQ-015 Port O_pkt_cnt, output, CNT_W, count of completed packets.

Function
REQ-016 The FSM SHALL have states IDLE, HDR, PAY and TRL; TRL is present only when the checksum feature is compiled in.
REQ-017 In IDLE, when I_start=1, the block SHALL latch I_len into the length and remaining-count registers and enter HDR on the next edge.
REQ-018 I_start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-019 In HDR: O_w_en=~I_w_full and O_w_data=latched length; on a write, the FSM SHALL go to PAY if length>0, else to TRL (checksum on) or IDLE (checksum off).
REQ-020 In PAY: O_s_ready=~I_w_full, O_w_en=I_s_valid&~I_w_full and O_w_data=I_s_data, combinationally with zero latency.
REQ-021 In PAY, each write SHALL decrement the remaining count; the write with remaining=1 SHALL move the FSM to TRL (checksum on) or IDLE (checksum off).
REQ-022 O_w_en SHALL never be high while I_w_full=1, so that no FIFO entry is overwritten.
REQ-023 Outside PAY, O_s_ready SHALL be 0.
REQ-024 When I_w_full deasserts, a stalled word SHALL be written in that same cycle, with no bubble.
REQ-025 O_done SHALL be a registered pulse, high for exactly one cycle, in the cycle after the final word of a packet is written.
REQ-026 O_pkt_cnt SHALL increment by 1 in the same edge that sets O_done, and SHALL wrap modulo 2^CNT_W.
REQ-027 Back-to-back packets: I_start may be accepted in the first IDLE cycle after completion, while O_done is high.
REQ-028 O_w_data SHALL be 0 whenever O_w_en=0.

Reset
REQ-029 While I_rst_n=0, the block SHALL force state=IDLE, the remaining count, latched length and checksum to 0, and O_done=0 and O_pkt_cnt=0.
REQ-030 While I_rst_n=0, the block SHALL drive O_w_en=0, O_s_ready=0 and O_busy=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately, and no further write SHALL be issued.
REQ-032 Reset release SHALL be synchronised by the integrator; the block SHALL treat the first rising edge after release as a normal IDLE cycle.

Configuration
REQ-033 Macro FIFO_PKT_WRITER_CSUM_EN defined: the block SHALL hold a WIDTH-bit checksum, XOR-accumulated over the header and every payload word written, cleared on entering HDR.
REQ-034 With FIFO_PKT_WRITER_CSUM_EN defined, in TRL the block SHALL drive O_w_en=~I_w_full and O_w_data=checksum, and SHALL go to IDLE after the write.
REQ-035 Macro FIFO_PKT_WRITER_CSUM_EN undefined: the block SHALL contain no checksum register and no TRL state, and each packet SHALL be header plus payload only.

Verification
REQ-036 Scenario: I_len=3, payload 0xA1,0xB2,0xC3, I_w_full=0 -> writes 0x03,0xA1,0xB2,0xC3 on consecutive cycles; with CSUM_EN, a fifth write of 0x03^0xA1^0xB2^0xC3=0xD3; O_done one cycle later; O_pkt_cnt=1.
REQ-037 Scenario: I_w_full=1 for 4 cycles mid-payload with I_s_valid=1 -> O_w_en=0 and O_s_ready=0 for those 4 cycles; the held word is written in the first cycle full=0; no word lost or duplicated.
REQ-038 Scenario: I_len=0 -> only header 0x00 written (plus trailer 0x00 with CSUM_EN); O_done pulses once.
REQ-039 Scenario: I_start pulsed during PAY of an I_len=5 packet -> ignored; exactly 6 (7 with CSUM_EN) writes; O_pkt_cnt=1.
REQ-040 Scenario: I_rst_n=0 after the 2nd payload word of I_len=8 -> O_w_en=0 from reset assertion onward, O_pkt_cnt=0 and O_busy=0; a new I_len=1 packet then completes normally.
REQ-041 Scenario: CNT_W=2 with 5 packets -> O_pkt_cnt sequence 1,2,3,0,1.
